// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter stage with BOOT/RUN/HALT control
// Registered fetch address with jump, stall and halt/resume redirects.
module pc_sequencer #(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             valid,
  output logic             halted
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_valid;
  logic             r_halted;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_valid_nxt;
  logic             w_halted_nxt;
  logic [WIDTH-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + INC_W;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    case (r_state)
      S_BOOT: begin
        w_state_nxt  = S_RUN;
        w_pc_nxt     = RESET_VECTOR;
        w_valid_nxt  = 1'b1;
        w_halted_nxt = 1'b0;
      end
      S_RUN: begin
        w_valid_nxt  = 1'b1;
        w_halted_nxt = 1'b0;
        // halt wins over a simultaneous jump, which is dropped
        if (halt_req) begin
          w_state_nxt  = S_HALT;
          w_valid_nxt  = 1'b0;
          w_halted_nxt = 1'b1;
        end else if (jump_en) begin
          w_pc_nxt = jump_addr;
        end else if (!stall) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      S_HALT: begin
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
        if (jump_en) begin
          w_pc_nxt = jump_addr;
        end
        if (resume) begin
          w_state_nxt  = S_RUN;
          w_valid_nxt  = 1'b1;
          w_halted_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_BOOT;
        w_pc_nxt     = RESET_VECTOR;
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_VECTOR;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign pc      = r_pc;
  assign pc_plus = w_pc_inc;
  assign valid   = r_valid;
  assign halted  = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       halt_req;
  logic       resume;
  logic [7:0] pc;
  logic [7:0] pc_plus;
  logic       valid;
  logic       halted;

  int n_checks;
  int n_fail;

  pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h00), .INC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .halt_req  (halt_req),
    .resume    (resume),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .valid     (valid),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_pc,
                             input logic e_valid, input logic e_halted);
    check_eq({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check_eq({tag, ".pc_plus"}, 32'(pc_plus), 32'(8'(e_pc + 8'd1)));
    check_eq({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check_eq({tag, ".halted"}, 32'(halted), 32'(e_halted));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    stall     = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 8'h00;
    halt_req  = 1'b0;
    resume    = 1'b0;

    // 1: reset and boot
    #1;
    check_state("reset", 8'h00, 1'b0, 1'b0);
    #11;
    rst = 1'b0;
    #1;
    check_state("released", 8'h00, 1'b0, 1'b0);
    tick();
    check_state("boot", 8'h00, 1'b1, 1'b0);
    tick(); check_state("run1", 8'h01, 1'b1, 1'b0);
    tick(); check_state("run2", 8'h02, 1'b1, 1'b0);
    tick(); check_state("run3", 8'h03, 1'b1, 1'b0);
    tick(); tick();
    check_state("run5", 8'h05, 1'b1, 1'b0);

    // 2: stall, then jump under stall
    stall = 1'b1;
    tick(); check_state("stall1", 8'h05, 1'b1, 1'b0);
    tick(); check_state("stall2", 8'h05, 1'b1, 1'b0);
    jump_en = 1'b1; jump_addr = 8'h40;
    tick(); check_state("jump_stall", 8'h40, 1'b1, 1'b0);
    jump_en = 1'b0; stall = 1'b0;
    tick(); check_state("after_jump", 8'h41, 1'b1, 1'b0);

    // 3: wrap
    jump_en = 1'b1; jump_addr = 8'hFE;
    tick(); check_state("wrap_fe", 8'hFE, 1'b1, 1'b0);
    jump_en = 1'b0;
    tick(); check_state("wrap_ff", 8'hFF, 1'b1, 1'b0);
    check_eq("wrap_pc_plus_ff", 32'(pc_plus), 32'h00);
    tick(); check_state("wrap_00", 8'h00, 1'b1, 1'b0);
    tick(); check_state("wrap_01", 8'h01, 1'b1, 1'b0);

    // 4: halt drops same-cycle jump, jump in HALT, resume
    jump_en = 1'b1; jump_addr = 8'h10;
    tick(); check_state("goto10", 8'h10, 1'b1, 1'b0);
    halt_req = 1'b1; jump_addr = 8'h20;
    tick(); check_state("halt_enter", 8'h10, 1'b0, 1'b1);
    halt_req = 1'b0; jump_addr = 8'h30; stall = 1'b1;
    tick(); check_state("halt_jump", 8'h30, 1'b0, 1'b1);
    jump_en = 1'b0; halt_req = 1'b1;
    tick(); check_state("halt_hold", 8'h30, 1'b0, 1'b1);
    halt_req = 1'b0; stall = 1'b0; resume = 1'b1;
    tick(); check_state("resume", 8'h30, 1'b1, 1'b0);
    resume = 1'b0;
    tick(); check_state("resume_run", 8'h31, 1'b1, 1'b0);

    // 5: resume together with jump
    halt_req = 1'b1;
    tick(); check_state("halt2", 8'h31, 1'b0, 1'b1);
    halt_req = 1'b0; resume = 1'b1; jump_en = 1'b1; jump_addr = 8'h7A;
    tick(); check_state("resume_jump", 8'h7A, 1'b1, 1'b0);
    resume = 1'b0; jump_en = 1'b0;
    tick(); check_state("resume_jump_run", 8'h7B, 1'b1, 1'b0);

    // 6: asynchronous reset between edges, boot ignores controls
    jump_en = 1'b1; jump_addr = 8'h55;
    tick(); check_state("goto55", 8'h55, 1'b1, 1'b0);
    jump_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    jump_en = 1'b1; jump_addr = 8'h99; halt_req = 1'b1;
    tick(); check_state("reboot", 8'h00, 1'b1, 1'b0);
    jump_en = 1'b0; halt_req = 1'b0;
    tick(); check_state("reboot_run1", 8'h01, 1'b1, 1'b0);
    tick(); check_state("reboot_run2", 8'h02, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage for the CPU datapath. Built as a bank of edge-triggered state bits with next-state control.
- Produces the fetch address each cycle.
- Accepts jump redirects, stall and halt/resume control from the control unit.
- Its registered pc output feeds the instruction-fetch stage directly downstream.

Parameters:
WIDTH, 8, bit width of the program counter and jump address
RESET_VECTOR, 8'h00, pc value loaded on reset
INC, 1, amount added to pc per advancing cycle

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold pc this cycle (RUN only)
jump_en  input  1  load jump_addr on next edge
jump_addr  input  WIDTH  redirect target
halt_req  input  1  request entry to HALT
resume  input  1  leave HALT
pc  output  WIDTH  current fetch address (registered)
pc_plus  output  WIDTH  pc + INC mod 2^WIDTH (combinational from pc; link value)
valid  output  1  pc is a valid fetch address this cycle (registered)
halted  output  1  high while in HALT (registered)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). No other clock or reset domain.
- While rst=1, immediately and independent of clk: pc=RESET_VECTOR, state=BOOT, valid=0, halted=0.
- States: BOOT, RUN, HALT. Encoding is free; outputs are registered from state.
- BOOT:
  - First rising edge after rst deasserts moves to RUN.
  - pc stays at RESET_VECTOR; valid becomes 1.
  - All control inputs are ignored in BOOT.
- RUN, priority at each edge, highest first:
  1. halt_req=1: -> HALT; pc holds; valid=0; halted=1. A jump_en in the same cycle is dropped.
  2. jump_en=1: pc=jump_addr. Takes effect even if stall=1.
  3. stall=1: pc holds.
  4. Otherwise: pc = pc + INC.
- Arithmetic is modulo 2^WIDTH. pc = 2^WIDTH-1 with INC=1 wraps to 0. No overflow flag.
- HALT:
  - pc holds. valid=0, halted=1. stall and halt_req are ignored.
  - jump_en=1 loads jump_addr into pc; state remains HALT unless resume=1.
  - resume=1: -> RUN; valid=1, halted=0.
  - resume=1 with jump_en=1: pc=jump_addr and -> RUN on the same edge.
- Latency: every control input affects pc/valid/halted on the next rising edge. pc_plus tracks pc combinationally with zero latency.
- valid and halted are never both 1. In BOOT both are 0.
- Reset mid-operation, in any state: outputs go to reset values asynchronously. The next edge after release behaves as BOOT.
- No X propagation: all state bits are reset.

Test Plan (WIDTH=8, RESET_VECTOR=0, INC=1):
1. Assert rst at t=0, release at t=12, clk period 10 -> pc=00, valid=0 until the first posedge after release. Then valid=1, pc=00, and pc=01, 02, 03 on the following edges; pc_plus always equals pc+1.
2. In RUN at pc=05, assert stall for 2 cycles, then jump_en=1 with jump_addr=8'h40 and stall=1 -> pc holds 05 for 2 edges, then loads 40, then 41.
3. Jump to 8'hFE, run freely -> pc = FE, FF, 00, 01 (wrap). pc_plus at FF reads 00.
4. At pc=10, assert halt_req and jump_en (addr 20) together -> HALT: pc stays 10, valid=0, halted=1. Then jump_en=1 with addr 30 in HALT -> pc=30, still halted. Then resume=1 -> RUN, pc=30 next cycle, then 31.
5. In HALT, assert resume=1 and jump_en=1 with addr 7A together -> pc=7A, valid=1, halted=0 on the same edge.
6. Assert rst asynchronously between edges while pc=55 in RUN -> pc=00, valid=0 immediately, before the next edge. After release, the BOOT sequence of scenario 1 repeats.
